// File: rtl/alarm_unit_pkg.sv
// Shared state encoding, time limits and BCD helpers for the alarm stage.
package alarm_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    localparam int unsigned MAX_HR      = 23;
    localparam int unsigned MAX_MIN     = 59;
    localparam int unsigned SEC_PER_MIN = 60;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return t[3:0];
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        logic [5:0] t;
        t = v % 6'd10;
        return t[3:0];
    endfunction

endpackage

// File: rtl/alarm_unit_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Synchronise, accept a new level after DEBOUNCE_CYCLES equal samples, pulse on rise
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                    pulse  <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: settable alarm time, time compare, buzzer with stop and snooze.
module alarm_unit
    import alarm_unit_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RING_SECONDS    = 60,
    parameter int unsigned SNOOZE_MINUTES  = 5
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       sec_plus,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic       alarm_en,
    input  logic       set_mode,
    input  logic       al_hr_btn,
    input  logic       al_min_btn,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic [3:0] al_hr_1s,
    output logic [3:0] al_hr_10s,
    output logic [3:0] al_min_1s,
    output logic [3:0] al_min_10s,
    output logic       buzzer,
    output logic       armed,
    output logic       ringing
);

    localparam int unsigned RCW = $clog2(RING_SECONDS + 1);
    localparam int unsigned SCW = $clog2(SEC_PER_MIN * SNOOZE_MINUTES + 1);
    localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SECONDS - 1);
    localparam logic [SCW-1:0] SNZ_LOAD  = SCW'(SEC_PER_MIN * SNOOZE_MINUTES);

    logic hr_p, min_p, snooze_p, stop_p;
    logic sec_r, sec_tick;
    logic [4:0] al_hr;
    logic [5:0] al_min;
    logic match, fired, abort, enter_ring;

    alarm_state_t   state_q, state_d;
    logic [RCW-1:0] ring_cnt, ring_cnt_d;
    logic [SCW-1:0] snz_cnt, snz_cnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hr (
        .clk_100MHz(clk_100MHz), .reset(reset), .btn(al_hr_btn), .pulse(hr_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
        .clk_100MHz(clk_100MHz), .reset(reset), .btn(al_min_btn), .pulse(min_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_snooze (
        .clk_100MHz(clk_100MHz), .reset(reset), .btn(snooze_btn), .pulse(snooze_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clk_100MHz(clk_100MHz), .reset(reset), .btn(stop_btn), .pulse(stop_p));

    // One-clock tick on each rising edge of the 1 Hz input
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sec_r    <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            sec_r    <= sec_plus;
            sec_tick <= sec_plus & ~sec_r;
        end
    end

    // Alarm time editing; hour and minute wrap independently
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            al_hr  <= '0;
            al_min <= '0;
        end else if (set_mode) begin
            if (hr_p)
                al_hr <= (al_hr == 5'(MAX_HR)) ? '0 : al_hr + 5'd1;
            if (min_p)
                al_min <= (al_min == 6'(MAX_MIN)) ? '0 : al_min + 6'd1;
        end
    end

    assign match = (hours == al_hr) && (minutes == al_min);
    assign abort = !alarm_en || set_mode;
    assign enter_ring = (state_d == RINGING) && (state_q != RINGING);

    // Block re-triggering for the rest of the alarm minute once it has rung
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset)
            fired <= 1'b0;
        else if (!match)
            fired <= 1'b0;
        else if (enter_ring)
            fired <= 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            ring_cnt <= ring_cnt_d;
            snz_cnt  <= snz_cnt_d;
        end
    end

    // Next-state logic: abort first, then stop over snooze over tick
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt;
        snz_cnt_d  = snz_cnt;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (sec_tick && match && !fired) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
                RINGING: begin
                    if (stop_p) begin
                        state_d = ARMED;
                    end else if (snooze_p) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = SNZ_LOAD;
                    end else if (sec_tick) begin
                        ring_cnt_d = ring_cnt + 1'b1;
                        if (ring_cnt == RING_LAST)
                            state_d = ARMED;
                    end
                end
                SNOOZE: begin
                    if (stop_p) begin
                        state_d = ARMED;
                    end else if (sec_tick) begin
                        snz_cnt_d = snz_cnt - 1'b1;
                        if (snz_cnt == SCW'(1)) begin
                            state_d    = RINGING;
                            ring_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Status outputs and BCD digits
    always_comb begin
        ringing    = (state_q == RINGING);
        armed      = (state_q != IDLE);
        buzzer     = ringing && !abort && sec_plus;
        al_hr_10s  = bcd_tens({1'b0, al_hr});
        al_hr_1s   = bcd_ones({1'b0, al_hr});
        al_min_10s = bcd_tens(al_min);
        al_min_1s  = bcd_ones(al_min);
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit.
module tb_alarm_unit;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       sec_plus;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic       alarm_en, set_mode;
    logic       al_hr_btn, al_min_btn, snooze_btn, stop_btn;
    logic [3:0] al_hr_1s, al_hr_10s, al_min_1s, al_min_10s;
    logic       buzzer, armed, ringing;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    alarm_unit #(
        .DEBOUNCE_CYCLES(4),
        .RING_SECONDS(5),
        .SNOOZE_MINUTES(1)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .sec_plus(sec_plus),
        .hours(hours),
        .minutes(minutes),
        .alarm_en(alarm_en),
        .set_mode(set_mode),
        .al_hr_btn(al_hr_btn),
        .al_min_btn(al_min_btn),
        .snooze_btn(snooze_btn),
        .stop_btn(stop_btn),
        .al_hr_1s(al_hr_1s),
        .al_hr_10s(al_hr_10s),
        .al_min_1s(al_min_1s),
        .al_min_10s(al_min_10s),
        .buzzer(buzzer),
        .armed(armed),
        .ringing(ringing)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk_100MHz);
        #1;
    endtask

    // mask bits: {stop, snooze, min, hr}
    task automatic press(input logic [3:0] mask);
        {stop_btn, snooze_btn, al_min_btn, al_hr_btn} = mask;
        repeat (12) wait_clk();
        {stop_btn, snooze_btn, al_min_btn, al_hr_btn} = 4'b0000;
        repeat (12) wait_clk();
    endtask

    task automatic sec_rise();
        sec_plus = 1'b1;
        repeat (4) wait_clk();
    endtask

    task automatic sec_fall();
        sec_plus = 1'b0;
        repeat (4) wait_clk();
    endtask

    task automatic tick();
        sec_rise();
        sec_fall();
    endtask

    // Leave the alarm minute and return so fired clears; ends inside a high second
    task automatic retrigger();
        minutes = 6'd31;
        repeat (2) wait_clk();
        minutes = 6'd30;
        repeat (2) wait_clk();
        sec_rise();
    endtask

    task automatic check_bcd(input string tag, input logic [3:0] h10, input logic [3:0] h1,
                             input logic [3:0] m10, input logic [3:0] m1);
        check({tag, "_hr10"},  {4'h0, al_hr_10s},  {4'h0, h10});
        check({tag, "_hr1"},   {4'h0, al_hr_1s},   {4'h0, h1});
        check({tag, "_min10"}, {4'h0, al_min_10s}, {4'h0, m10});
        check({tag, "_min1"},  {4'h0, al_min_1s},  {4'h0, m1});
    endtask

    initial begin
        reset = 1'b1;
        sec_plus = 1'b0;
        hours = 5'd0;
        minutes = 6'd0;
        alarm_en = 1'b0;
        set_mode = 1'b0;
        {stop_btn, snooze_btn, al_min_btn, al_hr_btn} = 4'b0000;
        repeat (3) wait_clk();

        check("rst_buzzer",  {7'd0, buzzer},  8'd0);
        check("rst_armed",   {7'd0, armed},   8'd0);
        check("rst_ringing", {7'd0, ringing}, 8'd0);
        check_bcd("rst", 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b0;
        wait_clk();

        // Edit with wrap: 25 hour presses -> 01, 61 minute presses -> 01
        set_mode = 1'b1;
        for (int i = 0; i < 25; i++) press(4'b0001);
        for (int i = 0; i < 61; i++) press(4'b0010);
        check_bcd("edit_wrap", 4'd0, 4'd1, 4'd0, 4'd1);

        // Presses with set_mode low are dropped
        set_mode = 1'b0;
        press(4'b0001);
        press(4'b0010);
        check_bcd("edit_locked", 4'd0, 4'd1, 4'd0, 4'd1);

        // 3-clk glitch is rejected, 10-clk hold counts once
        set_mode = 1'b1;
        al_min_btn = 1'b1;
        repeat (3) wait_clk();
        al_min_btn = 1'b0;
        repeat (12) wait_clk();
        check("glitch_min1", {4'h0, al_min_1s}, 8'd1);
        al_min_btn = 1'b1;
        repeat (10) wait_clk();
        al_min_btn = 1'b0;
        repeat (12) wait_clk();
        check("stable_min1", {4'h0, al_min_1s}, 8'd2);

        // Simultaneous hour and minute presses both apply: 01:02 -> 02:03
        press(4'b0011);
        check_bcd("both_edit", 4'd0, 4'd2, 4'd0, 4'd3);

        // Set alarm to 07:30
        for (int i = 0; i < 5; i++) press(4'b0001);
        for (int i = 0; i < 27; i++) press(4'b0010);
        check_bcd("al_0730", 4'd0, 4'd7, 4'd3, 4'd0);

        // Arm, no trigger at 07:29
        set_mode = 1'b0;
        alarm_en = 1'b1;
        hours = 5'd7;
        minutes = 6'd29;
        repeat (3) wait_clk();
        check("armed_on", {7'd0, armed}, 8'd1);
        tick();
        check("no_ring_0729", {7'd0, ringing}, 8'd0);

        // Trigger at 07:30 on the next second edge; buzzer follows sec_plus
        minutes = 6'd30;
        sec_rise();
        check("trig_ringing", {7'd0, ringing}, 8'd1);
        check("trig_buzz_hi", {7'd0, buzzer},  8'd1);
        sec_fall();
        check("trig_buzz_lo", {7'd0, buzzer},  8'd0);
        check("trig_ring_lo", {7'd0, ringing}, 8'd1);

        // Rings for 5 further ticks, then back to ARMED, no re-ring this minute
        for (int i = 0; i < 4; i++) tick();
        check("ring_4ticks", {7'd0, ringing}, 8'd1);
        sec_rise();
        check("auto_stop_ringing", {7'd0, ringing}, 8'd0);
        check("auto_stop_armed",   {7'd0, armed},   8'd1);
        check("auto_stop_buzzer",  {7'd0, buzzer},  8'd0);
        sec_fall();
        tick();
        tick();
        check("no_reretrigger", {7'd0, ringing}, 8'd0);

        // Snooze: silent for 59 ticks, rings again on the 60th
        retrigger();
        check("snz_pre_ring", {7'd0, ringing}, 8'd1);
        sec_fall();
        press(4'b0100);
        check("snz_ringing", {7'd0, ringing}, 8'd0);
        check("snz_armed",   {7'd0, armed},   8'd1);
        sec_rise();
        check("snz_buzzer", {7'd0, buzzer}, 8'd0);
        sec_fall();
        for (int i = 0; i < 58; i++) tick();
        check("snz_59", {7'd0, ringing}, 8'd0);
        sec_rise();
        check("snz_60_ring", {7'd0, ringing}, 8'd1);
        check("snz_60_buzz", {7'd0, buzzer},  8'd1);
        sec_fall();

        // Stop alone
        press(4'b1000);
        check("stop_ringing", {7'd0, ringing}, 8'd0);
        check("stop_armed",   {7'd0, armed},   8'd1);

        // Stop and snooze together: stop wins, nothing rings 60 ticks later
        retrigger();
        check("both_pre_ring", {7'd0, ringing}, 8'd1);
        sec_fall();
        press(4'b1100);
        check("both_ringing", {7'd0, ringing}, 8'd0);
        check("both_armed",   {7'd0, armed},   8'd1);
        for (int i = 0; i < 61; i++) tick();
        check("both_no_snooze", {7'd0, ringing}, 8'd0);

        // alarm_en low mid-ring -> IDLE next clock, buzzer silent
        retrigger();
        check("abort_pre_buzz", {7'd0, buzzer}, 8'd1);
        alarm_en = 1'b0;
        wait_clk();
        check("abort_buzzer",  {7'd0, buzzer},  8'd0);
        check("abort_ringing", {7'd0, ringing}, 8'd0);
        check("abort_armed",   {7'd0, armed},   8'd0);
        sec_fall();
        alarm_en = 1'b1;
        repeat (2) wait_clk();
        check("rearm", {7'd0, armed}, 8'd1);

        // Async reset mid-snooze clears everything before the next edge
        retrigger();
        sec_fall();
        press(4'b0100);
        tick();
        tick();
        check("pre_rst_armed", {7'd0, armed}, 8'd1);
        @(posedge clk_100MHz);
        #3;
        reset = 1'b1;
        #1;
        check("arst_armed",   {7'd0, armed},   8'd0);
        check("arst_ringing", {7'd0, ringing}, 8'd0);
        check("arst_buzzer",  {7'd0, buzzer},  8'd0);
        check_bcd("arst", 4'd0, 4'd0, 4'd0, 4'd0);
        wait_clk();
        reset = 1'b0;
        wait_clk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
